asrm_irq_ctrl: RTL and testbench

//  Parametrised nested interrupt controller for the asrm CPU; successor of the fixed 4-line unit.

---
 rtl/asrm_irq_ctrl_pkg.sv | 36 +++
 rtl/asrm_irq_sync.sv | 39 +++
 rtl/asrm_irq_ctrl.sv | 158 +++++++++++++++
 tb/tb_asrm_irq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrm_irq_ctrl_pkg.sv
// asrm_irq_ctrl_pkg: shared constants and helpers for the asrm interrupt controller.
//   Instruction encodings and the PC register-bus index are the asrm ISA values
//   shared with the rest of the CPU (inst_setint, inst_retint, pc_id).
//   lowest_set() is the fixed-priority encoder used for both arbitration and
//   retint bookkeeping (index 0 is the most urgent).
package asrm_irq_ctrl_pkg;

    localparam int unsigned MAX_INT = 16;   // channel select is 4 bits wide
    localparam int unsigned CH_W    = 4;
    localparam int unsigned REG_W   = 4;

    // inst_setint: {INST_SETINT_OP, channel}; inst_retint: full opcode byte
    localparam logic [3:0]       INST_SETINT_OP = 4'hE;
    localparam logic [7:0]       INST_RETINT    = 8'hF0;
    localparam logic [REG_W-1:0] PC_ID          = 4'hF;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] idx;
    } prio_t;

    // Lowest set bit of req, i.e. the most urgent requester.
    function automatic prio_t lowest_set(input logic [MAX_INT-1:0] req);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_INT - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/asrm_irq_sync.sv
// asrm_irq_sync: per-channel 2-FF synchroniser plus rising-edge detector.
//   clk, reset   clock, synchronous active-low reset
//   async_in     raw interrupt pin
//   level_o      synchronised level (second FF)
//   rise_c       one-cycle pulse on a synchronised 0->1 transition
module asrm_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level_o,
    output logic rise_c
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;   // previous synchronised value, for edge detection

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level_o = s2_q;
    assign rise_c  = s2_q & ~s3_q;

endmodule

// File: rtl/asrm_irq_ctrl.sv
// asrm_irq_ctrl: nested, fixed-priority interrupt controller for the asrm CPU.
//   clk, reset        clock, synchronous active-low reset
//   ext_int           asynchronous interrupt lines, one per channel
//   edge_mode         per channel: 1 = rising edge, 0 = level high
//   int_mask          per channel: 1 = enabled
//   cpu_update        CPU retires the current instruction this cycle
//   instruction       current opcode byte (setint channel in [3:0])
//   working_register  WR value, source of setint vectors
//   program_counter   PC of the current, not-yet-executed instruction
//   int_take          take interrupt this cycle ("int" is a reserved word)
//   out_routine       vector of the channel being taken
//   out, out_reg      register write bus contribution; 0 when idle
//   nest_level        return-address stack occupancy
// int_take, out_routine, out and out_reg are combinational from registered
// state and the current instruction, as the CPU consumes them in the same cycle.
module asrm_irq_ctrl
    import asrm_irq_ctrl_pkg::*;
#(
    parameter  int unsigned wordsize   = 16,
    parameter  int unsigned NUM_INT    = 8,
    parameter  int unsigned NEST_DEPTH = 4,
    localparam int unsigned LVL_W      = $clog2(NEST_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_INT-1:0]  ext_int,
    input  logic [NUM_INT-1:0]  edge_mode,
    input  logic [NUM_INT-1:0]  int_mask,
    input  logic                cpu_update,
    input  logic [7:0]          instruction,
    input  logic [wordsize-1:0] working_register,
    input  logic [wordsize-1:0] program_counter,
    output logic                int_take,
    output logic [wordsize-1:0] out_routine,
    output logic [wordsize-1:0] out,
    output logic [REG_W-1:0]    out_reg,
    output logic [LVL_W-1:0]    nest_level
);

    logic [NUM_INT-1:0]  sync_level;
    logic [NUM_INT-1:0]  sync_rise;

    logic [NUM_INT-1:0]  pending_q, pending_d;
    logic [NUM_INT-1:0]  in_service_q, in_service_d;
    logic [wordsize-1:0] vector_q [NUM_INT];
    logic [wordsize-1:0] vector_d [NUM_INT];
    logic [wordsize-1:0] stack_q  [NEST_DEPTH];
    logic [wordsize-1:0] stack_d  [NEST_DEPTH];
    logic [LVL_W-1:0]    sp_q, sp_d;

    logic [NUM_INT-1:0]  eligible;
    prio_t               win;
    prio_t               isr_top;
    logic                win_ok;
    logic                stack_full;
    logic                take_c;
    logic                setint_c;
    logic                retint_c;
    logic [wordsize-1:0] routine_c;
    logic [wordsize-1:0] stack_top_c;

    // One synchroniser/edge detector per channel
    for (genvar g = 0; g < NUM_INT; g++) begin : g_sync
        asrm_irq_sync u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (ext_int[g]),
            .level_o  (sync_level[g]),
            .rise_c   (sync_rise[g])
        );
    end

    // Arbitration and instruction decode
    always_comb begin
        eligible   = pending_q & int_mask & ~in_service_q;
        win        = lowest_set(MAX_INT'(eligible));
        isr_top    = lowest_set(MAX_INT'(in_service_q));
        // Only preempt when strictly more urgent than everything in service
        win_ok     = win.valid & (~isr_top.valid | (win.idx < isr_top.idx));
        stack_full = (sp_q == LVL_W'(NEST_DEPTH));
        take_c     = cpu_update & win_ok & ~stack_full;
        setint_c   = cpu_update & ~take_c & (instruction[7:4] == INST_SETINT_OP);
        retint_c   = cpu_update & ~take_c & (instruction == INST_RETINT) & (sp_q != '0);

        routine_c = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (win.idx == CH_W'(i)) routine_c = vector_q[i];
        end

        stack_top_c = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (sp_q == LVL_W'(i + 1)) stack_top_c = stack_q[i];
        end
    end

    // Next-state for pending, in-service, vectors and the return stack
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        vector_d     = vector_q;
        stack_d      = stack_q;
        sp_d         = sp_q;

        // Edge: a new rise wins over a same-cycle clear by the take
        for (int i = 0; i < NUM_INT; i++) begin
            if (edge_mode[i]) begin
                pending_d[i] = (pending_q[i] & ~(take_c & (win.idx == CH_W'(i))))
                               | sync_rise[i];
            end else begin
                pending_d[i] = sync_level[i];
            end
        end

        if (take_c) begin
            sp_d = sp_q + LVL_W'(1);
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (sp_q == LVL_W'(i)) stack_d[i] = program_counter;
            end
            for (int i = 0; i < NUM_INT; i++) begin
                if (win.idx == CH_W'(i)) in_service_d[i] = 1'b1;
            end
        end else if (setint_c) begin
            // Channels at or above NUM_INT match no entry and are ignored
            for (int i = 0; i < NUM_INT; i++) begin
                if (instruction[3:0] == CH_W'(i)) vector_d[i] = working_register;
            end
        end else if (retint_c) begin
            sp_d = sp_q - LVL_W'(1);
            for (int i = 0; i < NUM_INT; i++) begin
                if (isr_top.idx == CH_W'(i)) in_service_d[i] = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q    <= '0;
            in_service_q <= '0;
            vector_q     <= '{default: '0};
            stack_q      <= '{default: '0};
            sp_q         <= '0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            vector_q     <= vector_d;
            stack_q      <= stack_d;
            sp_q         <= sp_d;
        end
    end

    assign int_take    = take_c;
    assign out_routine = take_c ? routine_c : '0;
    assign out         = retint_c ? stack_top_c : '0;
    assign out_reg     = retint_c ? PC_ID : '0;
    assign nest_level  = sp_q;

endmodule

// File: tb/tb_asrm_irq_ctrl.sv
// tb_asrm_irq_ctrl: directed bench for asrm_irq_ctrl (NEST_DEPTH = 2) with a
// cycle-level behavioural model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_asrm_irq_ctrl;
    import asrm_irq_ctrl_pkg::*;

    localparam int unsigned WS = 16;
    localparam int unsigned NI = 8;
    localparam int unsigned ND = 2;
    localparam int unsigned LW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] ext_int, edge_mode, int_mask;
    logic          cpu_update;
    logic [7:0]    instruction;
    logic [WS-1:0] working_register, program_counter;
    logic          int_take;
    logic [WS-1:0] out_routine, out;
    logic [3:0]    out_reg;
    logic [LW-1:0] nest_level;

    localparam logic [7:0] NOP = 8'h00;

    always #5 clk = ~clk;

    asrm_irq_ctrl #(.wordsize(WS), .NUM_INT(NI), .NEST_DEPTH(ND)) dut (
        .clk              (clk),
        .reset            (reset),
        .ext_int          (ext_int),
        .edge_mode        (edge_mode),
        .int_mask         (int_mask),
        .cpu_update       (cpu_update),
        .instruction      (instruction),
        .working_register (working_register),
        .program_counter  (program_counter),
        .int_take         (int_take),
        .out_routine      (out_routine),
        .out              (out),
        .out_reg          (out_reg),
        .nest_level       (nest_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    logic [NI-1:0] m_pend, m_isr;
    logic [NI-1:0] pin_ago1, pin_ago2, pin_ago3;  // pin samples 1/2/3 edges back
    logic [WS-1:0] m_vec [NI];
    logic [WS-1:0] m_stack [$];

    function automatic void model_eval(output logic t, output int w,
                                       output logic [WS-1:0] rt,
                                       output logic [WS-1:0] ov,
                                       output logic [3:0] rg);
        int top = NI;
        w = -1;
        for (int i = NI - 1; i >= 0; i--) if (m_isr[i]) top = i;
        for (int i = NI - 1; i >= 0; i--)
            if (m_pend[i] && int_mask[i] && !m_isr[i]) w = i;
        t  = cpu_update && (w >= 0) && (w < top) && (m_stack.size() < ND);
        rt = '0;
        if (t) rt = m_vec[w];
        ov = '0;
        rg = '0;
        if (!t && cpu_update && instruction == INST_RETINT && m_stack.size() > 0) begin
            ov = m_stack[$];
            rg = PC_ID;
        end
    endfunction

    always @(posedge clk) begin : model_upd
        logic t; int w; logic [WS-1:0] rt, ov; logic [3:0] rg;
        if (!reset) begin
            m_pend = '0; m_isr = '0;
            pin_ago1 = '0; pin_ago2 = '0; pin_ago3 = '0;
            for (int i = 0; i < NI; i++) m_vec[i] = '0;
            m_stack.delete();
        end else begin
            model_eval(t, w, rt, ov, rg);
            // Pin is visible to the arbiter three edges after it is sampled
            for (int i = 0; i < NI; i++) begin
                if (edge_mode[i])
                    m_pend[i] = (m_pend[i] && !(t && w == i)) || (pin_ago2[i] && !pin_ago3[i]);
                else
                    m_pend[i] = pin_ago2[i];
            end
            if (t) begin
                m_stack.push_back(program_counter);
                m_isr[w] = 1'b1;
            end else if (cpu_update) begin
                if (instruction[7:4] == INST_SETINT_OP && int'(instruction[3:0]) < NI)
                    m_vec[instruction[3:0]] = working_register;
                if (instruction == INST_RETINT && m_stack.size() > 0) begin
                    void'(m_stack.pop_back());
                    for (int i = 0; i < NI; i++)
                        if (m_isr[i]) begin m_isr[i] = 1'b0; break; end
                end
            end
            pin_ago3 = pin_ago2; pin_ago2 = pin_ago1; pin_ago1 = ext_int;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model mid-cycle, then advance past the next edge
    task automatic tick();
        logic t; int w; logic [WS-1:0] rt, ov; logic [3:0] rg;
        @(negedge clk);
        model_eval(t, w, rt, ov, rg);
        check("cyc_int",         32'(int_take),         32'(t));
        check("cyc_out_routine", 32'(out_routine),      32'(rt));
        check("cyc_out",         32'(out),              32'(ov));
        check("cyc_out_reg",     32'(out_reg),          32'(rg));
        check("cyc_nest_level",  32'(nest_level),       32'(m_stack.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int(input string name, output int cyc);
        cyc = 0;
        #1;
        while (int_take !== 1'b1 && cyc < 12) begin
            tick();
            #1;
            cyc++;
        end
        check(name, 32'(int_take), 32'd1);
    endtask

    task automatic setint(input logic [3:0] ch, input logic [WS-1:0] v);
        instruction = {INST_SETINT_OP, ch};
        working_register = v;
        tick();
        instruction = NOP;
    endtask

    initial begin
        int cyc;
        reset = 1'b0; ext_int = '0; edge_mode = 8'hDF; int_mask = '0;
        cpu_update = 1'b1; instruction = NOP; working_register = '0; program_counter = '0;
        @(posedge clk); #1;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rst_int",   32'(int_take),   32'd0);
        check("rst_out",   32'(out),        32'd0);
        check("rst_reg",   32'(out_reg),    32'd0);
        check("rst_level", 32'(nest_level), 32'd0);
        tick();

        // 1: edge ch3, take on the 4th edge after the pin
        setint(4'd3, 16'h0120);
        int_mask = 8'h08; program_counter = 16'h0040;
        ext_int[3] = 1'b1;
        wait_int("t1_int", cyc);
        check("t1_latency", 32'(cyc), 32'd3);
        check("t1_routine", 32'(out_routine), 32'h0120);
        tick(); #1;
        check("t1_level", 32'(nest_level), 32'd1);

        // 2: nest ch1 under ch3, then unwind
        setint(4'd1, 16'h0200);
        int_mask = 8'h0A; program_counter = 16'h0125; ext_int[1] = 1'b1;
        wait_int("t2_int", cyc);
        check("t2_routine", 32'(out_routine), 32'h0200);
        tick(); #1;
        check("t2_level", 32'(nest_level), 32'd2);
        instruction = INST_RETINT; #1;
        check("t2_ret1_out", 32'(out), 32'h0125);
        check("t2_ret1_reg", 32'(out_reg), 32'(PC_ID));
        tick(); #1;
        check("t2_ret2_out", 32'(out), 32'h0040);
        tick();
        instruction = NOP; ext_int = '0;
        tick();

        // 3: depth-2 stack holds the third request until a retint
        setint(4'd0, 16'h0300);
        setint(4'd2, 16'h0500);
        int_mask = 8'h07; program_counter = 16'h0050; ext_int[2] = 1'b1;
        wait_int("t3_int_ch2", cyc);
        check("t3_routine_ch2", 32'(out_routine), 32'h0500);
        tick();
        program_counter = 16'h0501; ext_int[1] = 1'b1;
        wait_int("t3_int_ch1", cyc);
        check("t3_routine_ch1", 32'(out_routine), 32'h0200);
        tick();
        program_counter = 16'h0600; ext_int[0] = 1'b1;
        repeat (5) tick();
        #1;
        check("t3_full_int", 32'(int_take), 32'd0);
        check("t3_full_level", 32'(nest_level), 32'd2);
        instruction = INST_RETINT; #1;
        check("t3_ret_out", 32'(out), 32'h0501);
        tick();
        instruction = NOP; #1;
        check("t3_ch0_int", 32'(int_take), 32'd1);
        check("t3_ch0_routine", 32'(out_routine), 32'h0300);
        tick();
        instruction = INST_RETINT; #1;
        check("t3_ret_ch0", 32'(out), 32'h0600);
        tick(); #1;
        check("t3_ret_ch2", 32'(out), 32'h0050);
        tick();
        instruction = NOP; ext_int = '0;
        tick();

        // 4: level ch5, masked then unmasked; dropped line never fires
        setint(4'd5, 16'h0700);
        int_mask = '0; ext_int[5] = 1'b1;
        repeat (5) tick();
        int_mask = 8'h20; #1;
        check("t4_int", 32'(int_take), 32'd1);
        check("t4_routine", 32'(out_routine), 32'h0700);
        tick();
        ext_int[5] = 1'b0;
        repeat (4) tick();
        instruction = INST_RETINT;
        tick();
        instruction = NOP; #1;
        check("t4_level0", 32'(nest_level), 32'd0);
        int_mask = '0; ext_int[5] = 1'b1;
        repeat (4) tick();
        ext_int[5] = 1'b0;
        repeat (4) tick();
        int_mask = 8'h20;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_dropped_int", 32'(int_take), 32'd0);
            tick();
        end
        int_mask = '0;

        // 5: retint with empty stack, then reset mid-ISR
        instruction = INST_RETINT; #1;
        check("t5_empty_out", 32'(out), 32'd0);
        check("t5_empty_reg", 32'(out_reg), 32'd0);
        tick(); #1;
        check("t5_empty_level", 32'(nest_level), 32'd0);
        instruction = NOP; int_mask = 8'h01; ext_int[0] = 1'b1;
        wait_int("t5_int", cyc);
        tick(); #1;
        check("t5_level1", 32'(nest_level), 32'd1);
        reset = 1'b0; ext_int = '0;
        tick(); #1;
        check("t5_rst_level", 32'(nest_level), 32'd0);
        check("t5_rst_int", 32'(int_take), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 6: simultaneous ch0/ch7; ch7 waits for ch0's retint
        setint(4'd0, 16'h0300);
        setint(4'd7, 16'h0800);
        int_mask = 8'h81; program_counter = 16'h0700; ext_int = 8'h81;
        wait_int("t6_int_ch0", cyc);
        check("t6_routine_ch0", 32'(out_routine), 32'h0300);
        tick();
        repeat (3) tick();
        #1;
        check("t6_ch7_blocked", 32'(int_take), 32'd0);
        instruction = INST_RETINT; #1;
        check("t6_ret_out", 32'(out), 32'h0700);
        tick();
        instruction = NOP; #1;
        check("t6_int_ch7", 32'(int_take), 32'd1);
        check("t6_routine_ch7", 32'(out_routine), 32'h0800);
        tick();
        instruction = INST_RETINT;
        tick();
        instruction = NOP; ext_int = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
